eu_writeback_stage: RTL and testbench

- Result/writeback stage directly downstream of the execution unit's shifter/ALU output mux. It captures `data_out` plus destination address, derives Z/N/C status flags, and buffers results in a 2-entry FIFO.
- Results are handed to the register file over a valid/ready handshake.
- It decouples the combinational execute path from register-file write-port stalls.

---
 rtl/eu_writeback_stage.sv | 123 ++++++++++++
 tb/tb_eu_writeback_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/eu_writeback_stage.sv
// Writeback stage: derives Z/N/C, buffers results in a 2-entry FIFO, hands them to the register file.
// Optional same-cycle bypass into an empty FIFO when EU_WB_BYPASS_EN is defined.
module eu_writeback_stage #(
    parameter int unsigned BUS_WIDTH  = 16,
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [BUS_WIDTH-1:0]  in_b,
    input  logic [BUS_WIDTH-1:0]  in_result,
    input  logic                  in_alu_c,
    input  logic [REG_ADDR_W-1:0] in_dest,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [BUS_WIDTH-1:0]  wb_data,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  flag_c,
    output logic [1:0]            occupancy
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_MOVB = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;

    typedef struct packed {
        logic [BUS_WIDTH-1:0]  data;
        logic [REG_ADDR_W-1:0] dest;
        logic                  z;
        logic                  n;
        logic                  c;
    } entry_t;

    entry_t     mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] occ_q;

    entry_t in_entry_c;
    entry_t head_c;
    logic   is_nop_c;
    logic   bypass_c;
    logic   push_c;
    logic   pop_c;
    logic   fifo_pop_c;
    logic   unused_in_b_c;

    // Only the end bits of in_b feed the shifter carry.
    assign unused_in_b_c = ^in_b[BUS_WIDTH-2:1];

    // Entry formation and carry selection by op.
    always_comb begin
        in_entry_c      = '0;
        in_entry_c.data = in_result;
        in_entry_c.dest = in_dest;
        in_entry_c.z    = (in_result == '0);
        in_entry_c.n    = in_result[BUS_WIDTH-1];
        case (in_op)
            OP_SHR:  in_entry_c.c = in_b[0];
            OP_SHL:  in_entry_c.c = in_b[BUS_WIDTH-1];
            OP_MOVB: in_entry_c.c = 1'b0;
            default: in_entry_c.c = in_alu_c;
        endcase
    end

    assign is_nop_c = (in_op == OP_NOP);

`ifdef EU_WB_BYPASS_EN
    assign bypass_c = (occ_q == 2'd0) && in_valid && !is_nop_c;
`else
    assign bypass_c = 1'b0;
`endif

    assign head_c    = bypass_c ? in_entry_c : mem[rd_ptr];
    assign in_ready  = (occ_q != 2'd2);
    assign wb_valid  = (occ_q != 2'd0) || bypass_c;
    assign wb_data   = wb_valid ? head_c.data : '0;
    assign wb_dest   = wb_valid ? head_c.dest : '0;
    assign occupancy = occ_q;

    // A bypassed entry that commits immediately is never stored.
    assign pop_c      = wb_valid && wb_ready;
    assign fifo_pop_c = pop_c && !bypass_c;
    assign push_c     = in_valid && in_ready && !is_nop_c && !(bypass_c && wb_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            if (push_c)
                wr_ptr <= ~wr_ptr;
            if (fifo_pop_c)
                rd_ptr <= ~rd_ptr;
            if (push_c && !fifo_pop_c)
                occ_q <= occ_q + 2'd1;
            else if (fifo_pop_c && !push_c)
                occ_q <= occ_q - 2'd1;
            // Flags track the last committed result, not the last accepted one.
            if (pop_c) begin
                flag_z <= head_c.z;
                flag_n <= head_c.n;
                flag_c <= head_c.c;
            end
        end
    end

    // Storage needs no reset; validity is tracked by occupancy.
    always_ff @(posedge clk) begin
        if (push_c)
            mem[wr_ptr] <= in_entry_c;
    end

endmodule

// File: tb/tb_eu_writeback_stage.sv
// Randomized and directed bench for eu_writeback_stage against a queue-based reference model.
module tb_eu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_b;
    logic [15:0] in_result;
    logic        in_alu_c;
    logic [2:0]  in_dest;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [2:0]  wb_dest;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic [1:0]  occupancy;

    int unsigned total = 0;
    int unsigned bad   = 0;

`ifdef EU_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic [2:0]  dest;
        logic        z;
        logic        n;
        logic        c;
    } ref_entry_t;

    ref_entry_t q[$];
    logic [2:0] ref_flags = 3'b000;

    eu_writeback_stage #(.BUS_WIDTH(16), .REG_ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_b(in_b),
        .in_result(in_result), .in_alu_c(in_alu_c), .in_dest(in_dest),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dest(wb_dest),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ref_entry_t make_entry(input logic [3:0] op, input logic [15:0] b,
                                              input logic [15:0] r, input logic ac,
                                              input logic [2:0] d);
        ref_entry_t e;
        e.data = r;
        e.dest = d;
        e.z    = (r == 16'h0000);
        e.n    = r[15];
        if (op == 4'b1101)      e.c = b[0];
        else if (op == 4'b1110) e.c = b[15];
        else if (op == 4'b1100) e.c = 1'b0;
        else                    e.c = ac;
        return e;
    endfunction

    // One clock: drive at negedge, compare against the model, then advance the model for the next edge.
    task automatic step(input logic v, input logic [3:0] op, input logic [15:0] b,
                        input logic [15:0] r, input logic ac, input logic [2:0] d,
                        input logic wr, input logic rs);
        ref_entry_t e;
        ref_entry_t head;
        logic byp, exp_valid, accept, store;
        int sz;
        @(negedge clk);
        rst = rs; in_valid = v; in_op = op; in_b = b; in_result = r;
        in_alu_c = ac; in_dest = d; wb_ready = wr;
        #1;
        e  = make_entry(op, b, r, ac, d);
        sz = q.size();
        byp = BYPASS && (sz == 0) && v && (op != 4'b0000);
        exp_valid = (sz != 0) || byp;
        head = byp ? e : ((sz != 0) ? q[0] : '{default: '0});
        check("in_ready",  32'(in_ready),  32'(sz != 2));
        check("wb_valid",  32'(wb_valid),  32'(exp_valid));
        check("wb_data",   32'(wb_data),   exp_valid ? 32'(head.data) : 32'h0);
        check("wb_dest",   32'(wb_dest),   exp_valid ? 32'(head.dest) : 32'h0);
        check("occupancy", 32'(occupancy), 32'(sz));
        check("flags",     32'({flag_z, flag_n, flag_c}), 32'(ref_flags));
        if (rs) begin
            q.delete();
            ref_flags = 3'b000;
        end else begin
            accept = v && (sz != 2);
            store  = accept && (op != 4'b0000) && !(byp && wr);
            if (exp_valid && wr) begin
                ref_flags = {head.z, head.n, head.c};
                if (!byp) void'(q.pop_front());
            end
            if (store) q.push_back(e);
        end
    endtask

    task automatic idle(input logic wr);
        step(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 3'd0, wr, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 4'h0; in_b = 16'h0; in_result = 16'h0;
        in_alu_c = 1'b0; in_dest = 3'd0; wb_ready = 1'b0;
        repeat (2) @(posedge clk);
        idle(1'b0);
        check("reset_idle_flags", 32'({flag_z, flag_n, flag_c}), 32'h0);

        // SHR carry from in_b[0]
        step(1'b1, 4'b1101, 16'h1001, 16'h0800, 1'b0, 3'd3, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("shr_flags", 32'({flag_z, flag_n, flag_c}), 32'b001);

        // SHL zero result with carry, then MOVB negative
        step(1'b1, 4'b1110, 16'h8000, 16'h0000, 1'b0, 3'd1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("shl_flags", 32'({flag_z, flag_n, flag_c}), 32'b101);
        step(1'b1, 4'b1100, 16'hffff, 16'hface, 1'b1, 3'd2, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("movb_flags", 32'({flag_z, flag_n, flag_c}), 32'b010);

        // Backpressure until full, third push refused, then drain in order
        step(1'b1, 4'b0001, 16'h0, 16'hcafe, 1'b1, 3'd4, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 16'h0, 16'hface, 1'b0, 3'd5, 1'b0, 1'b0);
        step(1'b1, 4'b0011, 16'h0, 16'h1234, 1'b1, 3'd6, 1'b0, 1'b0);
        check("full_occ", 32'(occupancy), 32'd2);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Streaming at occupancy 1, then reset mid-stream
        step(1'b1, 4'b0101, 16'h0, 16'h0011, 1'b0, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 4'b0110, 16'h0, 16'(16'h0100 + i), 1'(i), 3'(i), 1'b1, 1'b0);
        step(1'b1, 4'b0111, 16'h0, 16'h7777, 1'b1, 3'd7, 1'b0, 1'b1);
        idle(1'b0);
        check("post_reset_occ", 32'(occupancy), 32'd0);

        // NOP completes handshake without storing
        step(1'b1, 4'b0000, 16'hffff, 16'h8000, 1'b1, 3'd2, 1'b1, 1'b0);
        idle(1'b1);

        // Random traffic including occasional reset
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            case ($urandom_range(0, 4))
                0:       op = 4'b0000;
                1:       op = 4'b1100;
                2:       op = 4'b1101;
                3:       op = 4'b1110;
                default: op = 4'($urandom);
            endcase
            step(1'($urandom_range(0, 3) != 0), op, 16'($urandom), 16'($urandom_range(0, 5) == 0 ? 0 : $urandom),
                 1'($urandom), 3'($urandom), 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
